// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a frame-aligned req/ack digit loader.
// Define LZ_BLANK_EN to blank leading zeros on digits 3..1.
module disp_scan_ctrl #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DIV_MAX = 49999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d_disp0,
    input  logic [3:0] d_disp1,
    input  logic [3:0] d_disp2,
    input  logic [3:0] d_disp3,
    input  logic       upd_req,
    output logic       upd_ack,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [DIV_W-1:0] CntMax = DIV_W'(DIV_MAX);

    typedef enum logic [1:0] {StIdle, StPend, StAck, StHold} state_e;

    state_e           state;
    logic [DIV_W-1:0] cnt;
    logic [1:0]       idx;
    logic [3:0][3:0]  shadow;
    logic             tick;
    logic             fb;
    logic             blank;
    logic [3:0]       digit;

    assign tick = (cnt == CntMax);
    assign fb   = tick && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            state   <= StIdle;
            upd_ack <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            upd_ack <= 1'b0;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            case (state)
                StIdle: if (upd_req) state <= StPend;
                StPend: begin
                    if (!upd_req) begin
                        state <= StIdle;
                    end else if (fb) begin
                        // Capture on the wrap edge so the new frame starts at digit 0.
                        shadow  <= {d_disp3, d_disp2, d_disp1, d_disp0};
                        state   <= StAck;
                        upd_ack <= 1'b1;
                    end
                end
                StAck:  state <= StHold;
                StHold: if (!upd_req) state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'ha: decode = 7'b0001000;
            4'hb: decode = 7'b0000011;
            4'hc: decode = 7'b1000110;
            4'hd: decode = 7'b0100001;
            4'he: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

`ifdef LZ_BLANK_EN
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd3:    blank = (shadow[3] == 4'd0);
            2'd2:    blank = (shadow[3] == 4'd0) && (shadow[2] == 4'd0);
            2'd1:    blank = (shadow[3] == 4'd0) && (shadow[2] == 4'd0) && (shadow[1] == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign digit = shadow[idx];
    assign an    = ~(4'b0001 << idx);
    assign seg   = blank ? 7'b1111111 : decode(digit);
    assign dp    = 1'b1;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed plus randomized bench for disp_scan_ctrl (DIV_MAX=3), checked against a
// cycle-count reference model of scan position, handshake and shadow digits.
module tb_disp_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic       upd_req = 1'b0;
    logic       upd_ack;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int failures = 0;

    // Reference model: t counts clocks since reset; scan position follows from t directly.
    int         t = 0;
    logic [3:0] m_dig [4];
    bit         waiting = 0, served = 0, m_ack = 0;
    int         ack_seen = 0;
    logic [6:0] seg_tbl [16];

    disp_scan_ctrl #(.DIV_W(16), .DIV_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .d_disp0(d0), .d_disp1(d1), .d_disp2(d2), .d_disp3(d3),
        .upd_req(upd_req), .upd_ack(upd_ack),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int cur_idx();
        return (t / 4) % 4;
    endfunction

    function automatic logic [6:0] exp_seg(input int i);
        int lz;
        lz = 0;
        if (m_dig[3] == 4'd0) begin
            lz = 1;
            if (m_dig[2] == 4'd0) begin
                lz = 2;
                if (m_dig[1] == 4'd0) lz = 3;
            end
        end
`ifdef LZ_BLANK_EN
        if (i > 0 && i >= 4 - lz) return 7'b1111111;
`endif
        return seg_tbl[m_dig[i]];
    endfunction

    task automatic cyc();
        bit         fb, prev;
        logic [3:0] e_an;
        @(posedge clk);
        if (rst) begin
            t = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
            waiting = 0; served = 0; m_ack = 0;
        end else begin
            fb   = (t % 16 == 15);
            prev = m_ack;
            m_ack = 0;
            if (waiting) begin
                if (!upd_req) waiting = 0;
                else if (fb) begin
                    m_dig[0] = d0; m_dig[1] = d1; m_dig[2] = d2; m_dig[3] = d3;
                    m_ack = 1; waiting = 0; served = 1;
                end
            end else if (served) begin
                if (!prev && !upd_req) served = 0;
            end else if (upd_req) begin
                waiting = 1;
            end
            t++;
        end
        #1;
        if (upd_ack === 1'b1) ack_seen++;
        e_an = 4'b0001 << cur_idx();
        chk("upd_ack", {7'd0, upd_ack}, {7'd0, m_ack});
        chk("an", {4'd0, an}, {4'd0, ~e_an});
        chk("seg", {1'b0, seg}, {1'b0, exp_seg(cur_idx())});
        chk("dp", {7'd0, dp}, 8'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic load_until_ack(input string tag);
        bit got;
        got = 0;
        upd_req = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            if (upd_ack === 1'b1) got = 1;
        end
        chk(tag, {7'd0, got}, 8'd1);
        upd_req = 1'b0;
    endtask

    initial begin
        logic [6:0] exp_blank;
        bit         toggle;
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;

        // Reset held two cycles
        rst = 1'b1;
        run(2);
        chk("rst_an", {4'd0, an}, 8'b0000_1110);
        chk("rst_seg", {1'b0, seg}, 8'b0100_0000);
        chk("rst_ack", {7'd0, upd_ack}, 8'd0);
        rst = 1'b0;
        run(3);
        chk("an_hold_4clk", {4'd0, an}, 8'b0000_1110);
        cyc();
        chk("an_step1", {4'd0, an}, 8'b0000_1101);
        run(12);

        // Load 4,3,2,1 and scan a full frame
        d3 = 4'd4; d2 = 4'd3; d1 = 4'd2; d0 = 4'd1;
        load_until_ack("load_ack");
        chk("load_d0_seg", {1'b0, seg}, 8'b0111_1001);
        run(20);

        // Held request yields exactly one ack
        d3 = 4'hd; d2 = 4'hc; d1 = 4'hb; d0 = 4'ha;
        upd_req = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (upd_ack === 1'b1) chk("ack_digit0", {1'b0, seg}, 8'b0000_1000);
        end
        chk("single_ack", ack_seen[7:0], 8'd1);
        upd_req = 1'b0;
        run(2);
        ack_seen = 0;
        load_until_ack("second_ack");
        chk("second_ack_cnt", ack_seen[7:0], 8'd1);
        run(3);

        // Withdrawn request mid-frame
        for (int i = 0; i < 20 && (t % 16 != 5); i++) cyc();
        upd_req = 1'b1;
        cyc();
        upd_req = 1'b0;
        ack_seen = 0;
        run(24);
        chk("withdraw_no_ack", ack_seen[7:0], 8'd0);

        // Reset while pending at idx 2
        upd_req = 1'b1;
        for (int i = 0; i < 20 && cur_idx() != 2; i++) cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_an", {4'd0, an}, 8'b0000_1110);
        chk("midrst_seg", {1'b0, seg}, 8'b0100_0000);
        rst = 1'b0;
        upd_req = 1'b0;
        ack_seen = 0;
        run(20);
        chk("midrst_no_ack", ack_seen[7:0], 8'd0);

        // Leading zeros 0,0,5,0
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd5; d0 = 4'd0;
        load_until_ack("blank_load");
`ifdef LZ_BLANK_EN
        exp_blank = 7'b1111111;
`else
        exp_blank = 7'b1000000;
`endif
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (cur_idx() == 3) chk("lz_digit3", {1'b0, seg}, {1'b0, exp_blank});
            if (cur_idx() == 2) chk("lz_digit2", {1'b0, seg}, {1'b0, exp_blank});
            if (cur_idx() == 1) chk("lz_digit1", {1'b0, seg}, 8'b0001_0010);
        end

        // Randomized traffic; digits change every cycle, occasional reset
        toggle = 0;
        for (int i = 0; i < 600; i++) begin
            d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
            if ($urandom_range(0, 7) == 0) toggle = ~toggle;
            upd_req = toggle;
            rst = ($urandom_range(0, 149) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
